ntt_butterfly_addsub: RTL and testbench

//  Downstream stage of modular_multiplier in the NTT butterfly datapath (Cooley-Tukey).
//  - Accepts a_in when its partner operands b, w enter the multiplier.
//  - Delays a_in by MUL_LAT to align it with the product p_in = b*w mod Q.
//  - Produces x = (a+p) mod Q and y = (a-p) mod Q.
//  - Buffers results in a FIFO with a valid/ready output handshake and credit-based input flow control.

---
 rtl/ntt_butterfly_addsub_pkg.sv | 25 ++
 rtl/ntt_butterfly_addsub_if.sv | 32 +++
 rtl/ntt_butterfly_addsub_mod_addsub.sv | 30 +++
 rtl/ntt_butterfly_addsub.sv | 116 +++++++++++
 tb/tb_ntt_butterfly_addsub.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_butterfly_addsub_pkg.sv
// +------------------------------------------------------------------+
// | ntt_butterfly_addsub_pkg: shared NTT butterfly widths and types  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ntt_butterfly_addsub_pkg;

    localparam int W       = 30;
    localparam logic [W-1:0] Q = 30'd1073479681;  // 2^30 - 2^18 + 1
    localparam int MUL_LAT = 3;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);

    typedef logic [W-1:0] word_t;

    typedef struct packed {
        word_t x;
        word_t y;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/ntt_butterfly_addsub_if.sv
// +------------------------------------------------------------------+
// | ntt_butterfly_addsub_if: input credit port and output handshake  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface ntt_butterfly_addsub_if;
    import ntt_butterfly_addsub_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t a_in;
    word_t p_in;
    logic  out_valid;
    logic  out_ready;
    word_t out_x;
    word_t out_y;
    logic  range_err;

    modport slave (
        input  in_valid, a_in, p_in, out_ready,
        output in_ready, out_valid, out_x, out_y, range_err
    );

    modport master (
        output in_valid, a_in, p_in, out_ready,
        input  in_ready, out_valid, out_x, out_y, range_err
    );

endinterface

`default_nettype wire

// File: rtl/ntt_butterfly_addsub_mod_addsub.sv
// +------------------------------------------------------------------+
// | mod_addsub: combinational (a,p) -> ((a+p) mod Q, (a-p) mod Q)    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mod_addsub
    import ntt_butterfly_addsub_pkg::*;
(
    input  word_t a,
    input  word_t p,
    output word_t x,
    output word_t y
);

    localparam logic [W:0] Q_EXT = {1'b0, Q};

    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, p};
    assign w_diff = {1'b0, a} - {1'b0, p};

    // Operands are < Q, so one conditional correction suffices in each direction.
    assign x = (w_sum >= Q_EXT) ? W'(w_sum - Q_EXT) : W'(w_sum);
    assign y = (a >= p)         ? W'(w_diff)        : W'(w_diff + Q_EXT);

endmodule

`default_nettype wire

// File: rtl/ntt_butterfly_addsub.sv
// +------------------------------------------------------------------+
// | ntt_butterfly_addsub: aligns a with b*w mod Q, outputs a+-p via  |
// | a credit-protected FIFO. Option macro: BFLY_RANGE_CHECK_EN       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ntt_butterfly_addsub
    import ntt_butterfly_addsub_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    ntt_butterfly_addsub_if.slave bus
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic             r_dly_v [MUL_LAT];
    word_t            r_dly_a [MUL_LAT];
    result_t          r_mem   [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [CNT_W-1:0] r_inflight;

    logic    w_accept;
    logic    w_pop;
    logic    w_wr;
    logic    w_out_valid;
    result_t w_res;
    result_t w_head;

    assign bus.in_ready = (r_inflight < DEPTH_C);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_pop        = w_out_valid & bus.out_ready;
    assign w_wr         = r_dly_v[MUL_LAT-1];

    // The multiplier cannot stall, so the delay line shifts unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_dly_v[i] <= 1'b0;
                r_dly_a[i] <= '0;
            end
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                r_dly_v[i] <= r_dly_v[i-1];
                r_dly_a[i] <= r_dly_a[i-1];
            end
            r_dly_v[0] <= w_accept;
            r_dly_a[0] <= bus.a_in;
        end
    end

    mod_addsub u_mod_addsub (
        .a (r_dly_a[MUL_LAT-1]),
        .p (bus.p_in),
        .x (w_res.x),
        .y (w_res.y)
    );

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Each accepted item reserves a FIFO slot until it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (w_accept && !w_pop) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign w_out_valid   = (r_wr_ptr != r_rd_ptr);
    assign w_head        = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign bus.out_valid = w_out_valid;
    assign bus.out_x     = w_out_valid ? w_head.x : '0;
    assign bus.out_y     = w_out_valid ? w_head.y : '0;

`ifdef BFLY_RANGE_CHECK_EN
    logic r_range_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if ((w_accept && (bus.a_in >= Q)) || (w_wr && (bus.p_in >= Q))) begin
            r_range_err <= 1'b1;
        end
    end

    assign bus.range_err = r_range_err;
`else
    assign bus.range_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntt_butterfly_addsub.sv
// +------------------------------------------------------------------+
// | tb_ntt_butterfly_addsub: directed vectors with queue scoreboard  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ntt_butterfly_addsub;
    import ntt_butterfly_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_butterfly_addsub_if bus ();

    ntt_butterfly_addsub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_pop  = 0;

    word_t ta [8];
    word_t tp [8];
    word_t tx [8];
    word_t ty [8];

    word_t          p_req;
    word_t          ex_x;
    word_t          ex_y;
    logic [2*W-1:0] sb [$];
    logic           s_acc;
    word_t          s_p;
    word_t          p_pipe [MUL_LAT];
    logic           hold_pending = 1'b0;
    word_t          hold_x;
    word_t          hold_y;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Multiplier stand-in: the product appears MUL_LAT cycles after the accept.
    assign bus.p_in = p_pipe[MUL_LAT-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) p_pipe[i] <= '0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) p_pipe[i] <= p_pipe[i-1];
            p_pipe[0] <= s_acc ? s_p : '0;
        end
    end

    // Scoreboard push on accept, pop/compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            sb.push_back({ex_x, ex_y});
            s_acc = 1'b1;
            s_p   = p_req;
        end else begin
            s_acc = 1'b0;
        end
        if (rst_n && bus.out_valid) begin
            if (hold_pending) begin
                check("hold_x", 64'(bus.out_x), 64'(hold_x));
                check("hold_y", 64'(bus.out_y), 64'(hold_y));
            end
            if (bus.out_ready) begin
                hold_pending = 1'b0;
                n_pop++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    logic [2*W-1:0] e;
                    e = sb.pop_front();
                    check("out_x", 64'(bus.out_x), 64'(e[2*W-1:W]));
                    check("out_y", 64'(bus.out_y), 64'(e[W-1:0]));
                end
            end else begin
                hold_pending = 1'b1;
                hold_x = bus.out_x;
                hold_y = bus.out_y;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic set_vec(input int i);
        bus.a_in = ta[i % 8];
        p_req    = tp[i % 8];
        ex_x     = tx[i % 8];
        ex_y     = ty[i % 8];
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || bus.out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Hold in_valid with the output stalled, then release and drain.
    task automatic fill_and_release();
        int nacc = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            set_vec(nacc);
            if (bus.in_ready) nacc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("fill_accepts", 64'(nacc), 64'd8);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_pop", 64'(bus.in_ready), 64'd1);
        drain();
    endtask

    initial begin
        int stalls;
        int pops0;
        int vcnt;
        ta = '{30'd100, 30'd1073479680, 30'd5, 30'd0, 30'd0, 30'd1073479680, 30'd536870912, 30'd1000};
        tp = '{30'd100000, 30'd1073479680, 30'd5, 30'd0, 30'd1, 30'd1, 30'd536870912, 30'd999};
        tx = '{30'd100100, 30'd1073479679, 30'd10, 30'd0, 30'd1, 30'd0, 30'd262143, 30'd1999};
        ty = '{30'd1073379781, 30'd0, 30'd0, 30'd0, 30'd1073479680, 30'd1073479679, 30'd0, 30'd1};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_vec(0);

        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_x", 64'(bus.out_x), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_range_err", 64'(bus.range_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Minimum latency MUL_LAT+1 from the accept cycle
        bus.out_ready = 1'b1;
        set_vec(0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (MUL_LAT - 1) @(posedge clk);
        #1;
        check("latency_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // Boundary operands, one at a time
        for (int i = 1; i < 8; i++) begin
            set_vec(i);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            drain();
        end

        fill_and_release();

        // Back-to-back stream of 20
        stalls = 0;
        pops0  = n_pop;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_vec(i);
            if (!bus.in_ready) stalls++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("stream_stalls", 64'(stalls), 64'd0);
        drain();
        check("stream_pops", 64'(n_pop - pops0), 64'd20);

        // Reset with items in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_vec(i + 2);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (MUL_LAT) @(posedge clk);
        #1;
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vcnt++;
        end
        check("post_reset_quiet", 64'(vcnt), 64'd0);
        check("post_reset_ready", 64'(bus.in_ready), 64'd1);
        fill_and_release();

        // Out-of-range operand
        bus.out_ready = 1'b1;
        bus.a_in = Q;
        p_req    = 30'd0;
        ex_x     = 30'd0;
        ex_y     = Q;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`ifdef BFLY_RANGE_CHECK_EN
        check("range_err_set", 64'(bus.range_err), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("range_err_sticky", 64'(bus.range_err), 64'd1);
`else
        check("range_err_off", 64'(bus.range_err), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("range_err_off_late", 64'(bus.range_err), 64'd0);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
